// File: rtl/dcm_reset_ctrl.sv
// Clock bring-up sequencer on the raw oscillator: pulses DCM reset, qualifies lock,
// then walks the PHY and core resets out; any clock trouble restarts from RST_DCM.
module dcm_reset_ctrl #(
   parameter int CNT_W           = 24,
   parameter int DCM_RST_CYCLES  = 8,
   parameter int LOCK_STABLE     = 1024,
   parameter int LOCK_TIMEOUT    = 1000000,
   parameter int PHY_RST_CYCLES  = 1000000,
   parameter int PHY_WAIT_CYCLES = 500000,
   parameter int MAX_RETRIES     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dcm_locked,
   input  logic       dcm_clkfx_stopped,
   output logic       dcm_rst,
   output logic       core_rst,
   output logic       phy_reset_n,
   output logic       ready,
   output logic       fault,
   output logic [7:0] retry_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      RST_DCM   = 3'd0,
      WAIT_LOCK = 3'd1,
      PHY_RST   = 3'd2,
      PHY_WAIT  = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
   localparam logic [CNT_W-1:0] DCM_LAST     = CNT_W'(DCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PHY_RST_LAST = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] PHY_WT_LAST  = CNT_W'(PHY_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_N     = CNT_W'(LOCK_STABLE);

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] stable_cnt;
   logic [CNT_W-1:0] stable_nxt;
   logic             locked_q;
   logic             locked_s;
   logic             stopped_q;
   logic             stopped_s;
   logic             retry;
   logic             clk_lost;
   logic [7:0]       retry_inc;

   assign state     = cur;
   assign clk_lost  = !locked_s || stopped_s;
   assign retry_inc = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;

   always_comb begin
      nxt        = cur;
      retry      = 1'b0;
      stable_nxt = locked_s ? stable_cnt + ONE : '0;
      case (cur)
         RST_DCM: begin
            if (cnt == DCM_LAST) nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // Lock acceptance wins over a same-cycle stop or timeout.
            if (stable_nxt == STABLE_N) begin
               nxt = PHY_RST;
            end else if (stopped_s && !locked_s) begin
               nxt   = RST_DCM;
               retry = 1'b1;
            end else if (cnt == TIMEOUT_LAST) begin
               nxt   = RST_DCM;
               retry = 1'b1;
            end
         end
         PHY_RST: begin
            if (clk_lost) begin
               nxt   = RST_DCM;
               retry = 1'b1;
            end else if (cnt == PHY_RST_LAST) begin
               nxt = PHY_WAIT;
            end
         end
         PHY_WAIT: begin
            if (clk_lost) begin
               nxt   = RST_DCM;
               retry = 1'b1;
            end else if (cnt == PHY_WT_LAST) begin
               nxt = RUN;
            end
         end
         RUN: begin
            if (clk_lost) begin
               nxt   = RST_DCM;
               retry = 1'b1;
            end
         end
         default: nxt = RST_DCM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= RST_DCM;
      end else begin
         cur <= nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked_q    <= 1'b0;
         locked_s    <= 1'b0;
         stopped_q   <= 1'b0;
         stopped_s   <= 1'b0;
         cnt         <= '0;
         stable_cnt  <= '0;
         dcm_rst     <= 1'b1;
         core_rst    <= 1'b1;
         phy_reset_n <= 1'b0;
         ready       <= 1'b0;
         fault       <= 1'b0;
         retry_count <= 8'd0;
      end else begin
         locked_q    <= dcm_locked;
         locked_s    <= locked_q;
         stopped_q   <= dcm_clkfx_stopped;
         stopped_s   <= stopped_q;
         cnt         <= (nxt != cur) ? '0 : cnt + ONE;
         stable_cnt  <= (cur == WAIT_LOCK && nxt == WAIT_LOCK) ? stable_nxt : '0;
         // Outputs follow the next state so they switch on the same edge as the state.
         dcm_rst     <= (nxt == RST_DCM);
         core_rst    <= (nxt != RUN);
         phy_reset_n <= (nxt == PHY_WAIT) || (nxt == RUN);
         ready       <= (nxt == RUN);
         if (retry) begin
            retry_count <= retry_inc;
            if (int'(retry_inc) >= MAX_RETRIES) fault <= 1'b1;
         end
      end
   end

endmodule
